// File: rtl/fmamult_pipe.sv
// Two-stage valid/ready floating-point multiplier feeding the FMA adder.
// S1 forms sign, significand product, exponent sum and operand class; S2 rounds and packs.
module fmamult_pipe #(
  parameter int EW = 5,
  parameter int MW = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EW+MW:0]    x,
  input  logic [EW+MW:0]    y,
  input  logic [1:0]        roundmode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW+MW:0]    product,
  output logic [2*MW+1:0]   fullPm,
  output logic [3:0]        flags
);
  localparam int W  = 1 + EW + MW;
  localparam int PW = 2 * MW + 2;
  localparam int XW = EW + 2;

  localparam logic [XW-1:0] BIAS_V = {3'b000, {(EW-1){1'b1}}};
  localparam logic [XW-1:0] EMAX_V = {2'b00, {EW{1'b1}}};
  localparam logic [XW-1:0] ZERO_X = {XW{1'b0}};
  localparam logic [XW-1:0] ONE_X  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  QNAN   = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RN  = 2'b10;
  localparam logic [1:0] RM_RP  = 2'b11;

  typedef enum logic [1:0] {
    CLS_NUM  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  function automatic logic round_inc(input logic [1:0] rm, input logic sgn,
                                     input logic lsb, input logic grd, input logic stk);
    logic inc;
    case (rm)
      RM_RNE:  inc = grd & (lsb | stk);
      RM_RP:   inc = ~sgn & (grd | stk);
      RM_RN:   inc = sgn & (grd | stk);
      RM_RZ:   inc = 1'b0;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  // Overflow saturates to infinity or to the largest finite value depending on direction.
  function automatic logic [W-1:0] ovf_result(input logic [1:0] rm, input logic sgn);
    logic to_inf;
    case (rm)
      RM_RNE:  to_inf = 1'b1;
      RM_RP:   to_inf = ~sgn;
      RM_RN:   to_inf = sgn;
      RM_RZ:   to_inf = 1'b0;
      default: to_inf = 1'b0;
    endcase
    return to_inf ? {sgn, {EW{1'b1}}, {MW{1'b0}}}
                  : {sgn, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
  endfunction

  logic             s1_valid_r, s2_valid_r;
  logic             adv1_s, adv2_s;
  logic             s1_sign_r;
  logic [PW-1:0]    s1_p_r;
  logic [XW-1:0]    s1_esum_r;
  cls_t             s1_cls_r;
  logic             s1_nv_r;
  logic [1:0]       s1_rm_r;

  logic [EW-1:0]    ex_s, ey_s;
  logic [MW-1:0]    mx_s, my_s;
  logic             x_zero_s, y_zero_s, x_max_s, y_max_s;
  logic             x_nan_s, y_nan_s, x_snan_s, y_snan_s, x_inf_s, y_inf_s, inv_s;
  cls_t             cls_s;
  logic             nv_s;
  logic [PW-1:0]    prod_s;
  logic [XW-1:0]    esum_s;

  logic [PW-2:0]    norm_s;
  logic [XW-1:0]    e_norm_s, e_fin_s;
  logic [MW-1:0]    mant_s;
  logic             grd_s, stk_s, inc_s;
  logic [MW:0]      mant_inc_s;
  logic [W-1:0]     res_s;
  logic [3:0]       flg_s;

  assign adv2_s    = ~s2_valid_r | out_ready;
  assign adv1_s    = ~s1_valid_r | adv2_s;
  assign in_ready  = adv1_s;
  assign out_valid = s2_valid_r;

  assign ex_s = x[W-2:MW];
  assign ey_s = y[W-2:MW];
  assign mx_s = x[MW-1:0];
  assign my_s = y[MW-1:0];

  assign x_zero_s = (ex_s == {EW{1'b0}});
  assign y_zero_s = (ey_s == {EW{1'b0}});
  assign x_max_s  = (ex_s == {EW{1'b1}});
  assign y_max_s  = (ey_s == {EW{1'b1}});
  assign x_nan_s  = x_max_s & (|mx_s);
  assign y_nan_s  = y_max_s & (|my_s);
  assign x_snan_s = x_nan_s & ~mx_s[MW-1];
  assign y_snan_s = y_nan_s & ~my_s[MW-1];
  assign x_inf_s  = x_max_s & ~(|mx_s);
  assign y_inf_s  = y_max_s & ~(|my_s);
  assign inv_s    = (x_inf_s & y_zero_s) | (y_inf_s & x_zero_s);

  // Stage-1 combinational: classify operands, form significand product and exponent sum.
  always_comb begin
    cls_s  = CLS_NUM;
    nv_s   = 1'b0;
    prod_s = {PW{1'b0}};
    esum_s = {2'b00, ex_s} + {2'b00, ey_s} - BIAS_V;
    if (x_nan_s | y_nan_s | inv_s) begin
      cls_s = CLS_NAN;
    end else if (x_inf_s | y_inf_s) begin
      cls_s = CLS_INF;
    end else if (x_zero_s | y_zero_s) begin
      cls_s = CLS_ZERO;
    end else begin
      cls_s = CLS_NUM;
    end
    nv_s = x_snan_s | y_snan_s | inv_s;
    if (cls_s == CLS_NUM) begin
      prod_s = {{(MW+1){1'b0}}, 1'b1, mx_s} * {{(MW+1){1'b0}}, 1'b1, my_s};
    end else begin
      prod_s = {PW{1'b0}};
    end
  end

  // Stage-1 register: loads whenever it can advance; a bubble is loaded when nothing is offered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_p_r     <= {PW{1'b0}};
      s1_esum_r  <= {XW{1'b0}};
      s1_cls_r   <= CLS_ZERO;
      s1_nv_r    <= 1'b0;
      s1_rm_r    <= 2'b00;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r <= x[W-1] ^ y[W-1];
        s1_p_r    <= prod_s;
        s1_esum_r <= esum_s;
        s1_cls_r  <= cls_s;
        s1_nv_r   <= nv_s;
        s1_rm_r   <= roundmode;
      end
    end
  end

  // Stage-2 combinational: normalise, round, detect range violations and pack.
  always_comb begin
    norm_s     = {(PW-1){1'b0}};
    e_norm_s   = s1_esum_r;
    res_s      = {W{1'b0}};
    flg_s      = 4'b0000;
    if (s1_p_r[PW-1]) begin
      norm_s   = s1_p_r[PW-2:0];
      e_norm_s = s1_esum_r + ONE_X;
    end else begin
      norm_s   = {s1_p_r[PW-3:0], 1'b0};
      e_norm_s = s1_esum_r;
    end
    mant_s     = norm_s[PW-2 -: MW];
    grd_s      = norm_s[PW-2-MW];
    stk_s      = |norm_s[PW-3-MW:0];
    inc_s      = round_inc(s1_rm_r, s1_sign_r, mant_s[0], grd_s, stk_s);
    mant_inc_s = {1'b0, mant_s} + {{MW{1'b0}}, inc_s};
    // A carry out of the mantissa leaves its field all-zero and bumps the exponent.
    e_fin_s    = e_norm_s + {{(XW-1){1'b0}}, mant_inc_s[MW]};
    case (s1_cls_r)
      CLS_NAN: begin
        res_s = QNAN;
        flg_s = {s1_nv_r, 3'b000};
      end
      CLS_INF: begin
        res_s = {s1_sign_r, {EW{1'b1}}, {MW{1'b0}}};
        flg_s = 4'b0000;
      end
      CLS_ZERO: begin
        res_s = {s1_sign_r, {(W-1){1'b0}}};
        flg_s = 4'b0000;
      end
      CLS_NUM: begin
        if ($signed(e_fin_s) >= $signed(EMAX_V)) begin
          res_s = ovf_result(s1_rm_r, s1_sign_r);
          flg_s = 4'b0101;
        end else if ($signed(e_fin_s) <= $signed(ZERO_X)) begin
          res_s = {s1_sign_r, {(W-1){1'b0}}};
          flg_s = 4'b0011;
        end else begin
          res_s = {s1_sign_r, e_fin_s[EW-1:0], mant_inc_s[MW-1:0]};
          flg_s = {3'b000, grd_s | stk_s};
        end
      end
      default: begin
        res_s = QNAN;
        flg_s = 4'b0000;
      end
    endcase
  end

  // Stage-2 register: drives the outputs, holds them while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_r <= 1'b0;
      product    <= {W{1'b0}};
      fullPm     <= {PW{1'b0}};
      flags      <= 4'b0000;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        product <= res_s;
        fullPm  <= s1_p_r;
        flags   <= flg_s;
      end
    end
  end

endmodule

// File: tb/tb_fmamult_pipe.sv
// Directed self-checking bench for fmamult_pipe (EW=5, MW=10) with hand-computed vectors.
module tb_fmamult_pipe;
  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [1:0]  roundmode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [21:0] fullPm;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] RZ = 2'b00, RNE = 2'b01, RN = 2'b10, RP = 2'b11;

  fmamult_pipe #(.EW(5), .MW(10)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .roundmode(roundmode), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .fullPm(fullPm), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // One isolated operation: accept, confirm one-cycle gap, then check the result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] rm, input logic [15:0] ep, input logic [3:0] ef,
                        input logic [21:0] epm);
    @(negedge clk);
    x = a; y = b; roundmode = rm; in_valid = 1'b1;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_product"}, product, ep);
    chk({tag, "_flags"}, flags, ef);
    chk({tag, "_fullPm"}, fullPm, epm);
  endtask

  logic [15:0] bx [4];
  logic [15:0] by [4];
  logic [15:0] bexp [4];
  int idx, oidx, acc;
  logic acc_now, fire_now;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; x = 16'h0000; y = 16'h0000;
    roundmode = RNE; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 16'h0000);
    chk("rst_flags", flags, 4'h0);
    chk("rst_fullPm", fullPm, 22'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    run_op("one_rne",   16'h3C00, 16'h3C00, RNE, 16'h3C00, 4'b0000, 22'h100000);
    run_op("m01_rz",    16'h3C01, 16'h3C01, RZ,  16'h3C02, 4'b0001, 22'h100801);
    run_op("m01_rne",   16'h3C01, 16'h3C01, RNE, 16'h3C02, 4'b0001, 22'h100801);
    run_op("m01_rp",    16'h3C01, 16'h3C01, RP,  16'h3C03, 4'b0001, 22'h100801);
    run_op("m01_rn",    16'h3C01, 16'h3C01, RN,  16'h3C02, 4'b0001, 22'h100801);
    run_op("tie_rne",   16'h3C01, 16'h3E00, RNE, 16'h3E02, 4'b0001, 22'h180600);
    run_op("tie_rz",    16'h3C01, 16'h3E00, RZ,  16'h3E01, 4'b0001, 22'h180600);
    run_op("carry_rne", 16'h3FFE, 16'h3C01, RNE, 16'h4000, 4'b0001, 22'h1FFFFE);
    run_op("ovf_rne",   16'h7BFF, 16'h7BFF, RNE, 16'h7C00, 4'b0101, 22'h3FF001);
    run_op("ovf_rz",    16'h7BFF, 16'h7BFF, RZ,  16'h7BFF, 4'b0101, 22'h3FF001);
    run_op("ovf_neg_rp", 16'hFBFF, 16'h7BFF, RP, 16'hFBFF, 4'b0101, 22'h3FF001);
    run_op("ovf_neg_rn", 16'hFBFF, 16'h7BFF, RN, 16'hFC00, 4'b0101, 22'h3FF001);
    run_op("emax_ok",   16'h7800, 16'h3C00, RNE, 16'h7800, 4'b0000, 22'h100000);
    run_op("emax_ovf",  16'h7800, 16'h4000, RNE, 16'h7C00, 4'b0101, 22'h100000);
    run_op("inf_zero",  16'h7C00, 16'h0000, RNE, 16'h7E00, 4'b1000, 22'h0);
    run_op("snan",      16'h7C01, 16'h3C00, RNE, 16'h7E00, 4'b1000, 22'h0);
    run_op("qnan",      16'h7E00, 16'h3C00, RNE, 16'h7E00, 4'b0000, 22'h0);
    run_op("inf_fin",   16'hFC00, 16'h3C00, RNE, 16'hFC00, 4'b0000, 22'h0);
    run_op("unf_deep",  16'h0400, 16'h0400, RNE, 16'h0000, 4'b0011, 22'h100000);
    run_op("unf_e0",    16'h0400, 16'h3800, RNE, 16'h0000, 4'b0011, 22'h100000);
    run_op("emin_ok",   16'h0400, 16'h3C00, RNE, 16'h0400, 4'b0000, 22'h100000);
    run_op("neg_zero",  16'h8000, 16'h3C00, RNE, 16'h8000, 4'b0000, 22'h0);

    // Backpressure: four back-to-back ops, downstream stalled for the first three cycles.
    bx[0] = 16'h3C00; by[0] = 16'h3C00; bexp[0] = 16'h3C00;
    bx[1] = 16'h3C01; by[1] = 16'h3C01; bexp[1] = 16'h3C02;
    bx[2] = 16'h4000; by[2] = 16'h4000; bexp[2] = 16'h4400;
    bx[3] = 16'h4200; by[3] = 16'h3C00; bexp[3] = 16'h4200;
    idx = 0; oidx = 0; acc = 0;
    for (int c = 0; c < 30 && oidx < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 3);
      in_valid  = (idx < 4);
      x = (idx < 4) ? bx[idx] : 16'h0000;
      y = (idx < 4) ? by[idx] : 16'h0000;
      roundmode = RNE;
      #1;
      if (c == 2) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_accepts", acc, 2);
        chk("bp_out_valid", out_valid, 1);
      end
      if (out_valid && oidx < 4) chk($sformatf("bp_product%0d_c%0d", oidx, c), product, bexp[oidx]);
      acc_now  = in_valid & in_ready;
      fire_now = out_valid & out_ready;
      @(posedge clk);
      if (acc_now) begin
        idx++;
        acc++;
      end
      if (fire_now) oidx++;
    end
    chk("bp_results", oidx, 4);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset with both stages full, then a fresh operation.
    out_ready = 1'b0;
    x = 16'h3C00; y = 16'h3C00; roundmode = RNE; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x = 16'h4000; y = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_in_ready", in_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_product", product, 16'h0000);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    run_op("post_rst", 16'h3C01, 16'h3E00, RNE, 16'h3E02, 4'b0001, 22'h180600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
